// File: rtl/c2h_pkg.sv
// Shared types and constants for the C2H source arbiter and its picker.
package c2h_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned ID_W_DEF    = $clog2(NUM_SRC_DEF);
  localparam int unsigned TMO_W       = 16;

endpackage

// File: rtl/c2h_src_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector to start at i_rr_ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  logic [2*NUM_SRC-1:0] w_dbl;
  logic [NUM_SRC-1:0]   w_rot;
  logic [ID_W-1:0]      w_idx;
  logic [ID_W:0]        w_sum;

  assign w_dbl = {i_req, i_req} >> i_rr_ptr;
  assign w_rot = w_dbl[NUM_SRC-1:0];

  always_comb begin
    w_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = ID_W'(i);
    end
  end

  // Undo the rotation modulo NUM_SRC (NUM_SRC need not be a power of two).
  assign w_sum    = {1'b0, w_idx} + {1'b0, i_rr_ptr};
  assign o_winner = (w_sum >= (ID_W+1)'(NUM_SRC)) ? ID_W'(w_sum - (ID_W+1)'(NUM_SRC))
                                                   : w_sum[ID_W-1:0];
  assign o_any    = |i_req;

endmodule

// File: rtl/c2h_src_arbiter.sv
// Shares one C2H packer among NUM_SRC record producers: round-robin grant,
// hold register, offer/busy handshake with the packer and an abort timeout.
module c2h_src_arbiter
  import c2h_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned DATA_WIDTH     = 4064,
  parameter int unsigned ID_W           = $clog2(NUM_SRC),
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          m_axis_c2h_aclk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0]         pkt_data,
  output logic                          pkt_data_valid,
  input  logic                          pkt_data_next,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                  r_state;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_grant_id;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic [DATA_WIDTH-1:0]   r_pkt_data;
  logic                    r_pkt_data_valid;
  logic                    r_pkt_done;
  logic                    r_timeout_err;

  logic [NUM_SRC-1:0]      w_req;
  logic [ID_W-1:0]         w_winner;
  logic                    w_any;
  logic                    w_grant;
  logic                    w_abort;
  logic [ID_W-1:0]         w_next_ptr;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  assign w_req = src_valid & src_en;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_grant    = (r_state == IDLE) && w_any && !rst;
  assign w_abort    = TMO_EN && (r_state != IDLE) && (r_tmo_cnt == TMO_LAST);
  assign w_next_ptr = (w_winner == ID_W'(NUM_SRC - 1)) ? '0 : w_winner + ID_W'(1);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_winner == ID_W'(i)) w_sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    src_ready = '0;
    if (w_grant) src_ready[w_winner] = 1'b1;
  end

  // Hold register: deliberately not reset, only loaded on a grant.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (w_grant) r_pkt_data <= w_sel_data;
  end

  always_ff @(posedge m_axis_c2h_aclk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rr_ptr         <= '0;
      r_grant_id       <= '0;
      r_tmo_cnt        <= '0;
      r_pkt_data_valid <= 1'b0;
      r_pkt_done       <= 1'b0;
      r_timeout_err    <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_abort)      r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id       <= w_winner;
            r_pkt_data_valid <= 1'b1;
            r_rr_ptr         <= w_next_ptr;
            r_tmo_cnt        <= '0;
            r_state          <= OFFER;
          end
        end
        OFFER: begin
          if (w_abort) begin
            r_pkt_data_valid <= 1'b0;
            r_state          <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (!pkt_data_next) begin
              r_pkt_data_valid <= 1'b0;
              r_state          <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (pkt_data_next) begin
              r_pkt_done <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pkt_data       = r_pkt_data;
  assign pkt_data_valid = r_pkt_data_valid;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state != IDLE);
  assign pkt_done       = r_pkt_done;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_c2h_src_arbiter.sv
// Randomized scoreboard bench for c2h_src_arbiter with a transaction-level
// round-robin model and an independent output monitor.
module tb_c2h_src_arbiter;

  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 2;
  localparam int unsigned TMO = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_en, src_valid, src_ready;
  logic [NS*DW-1:0]  src_data;
  logic [DW-1:0]     pkt_data;
  logic              pkt_data_valid, pkt_data_next;
  logic [IDW-1:0]    grant_id;
  logic              busy, pkt_done, timeout_err, err_clr;

  c2h_src_arbiter #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .ID_W(IDW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .m_axis_c2h_aclk(clk), .rst(rst), .src_en(src_en), .src_valid(src_valid),
    .src_ready(src_ready), .src_data(src_data), .pkt_data(pkt_data),
    .pkt_data_valid(pkt_data_valid), .pkt_data_next(pkt_data_next),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  logic [NS-1:0]  ready_q[$];
  logic [IDW-1:0] offer_id_q[$];
  logic [DW-1:0]  offer_data_q[$];
  logic [IDW-1:0] done_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] req, input int ptr);
    for (int k = 0; k < NS; k++) begin
      if (req[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b", busy);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = {$urandom, $urandom};
  endtask

  // Present sources to an idle arbiter; returns the modelled winner or -1.
  task automatic present(input logic [NS-1:0] en, input logic [NS-1:0] val, output int w);
    logic [NS-1:0] oh;
    wait_idle();
    src_en = en;
    src_valid = val;
    rand_data();
    w = pick(en & val, m_ptr);
    if (w >= 0) begin
      oh = '0;
      oh[w] = 1'b1;
      ready_q.push_back(oh);
      offer_id_q.push_back(IDW'(w));
      offer_data_q.push_back(src_data[w*DW +: DW]);
      m_ptr = (w + 1) % NS;
    end
    tick();
    src_valid = '0;
    rand_data();
  endtask

  task automatic run_pkt(input logic [NS-1:0] en, input logic [NS-1:0] val,
                         input int hold_hi, input int busy_lo);
    int w;
    present(en, val, w);
    if (w < 0) begin
      chk("idle_no_grant", busy, 1'b0);
      return;
    end
    done_q.push_back(IDW'(w));
    chk("busy_after_grant", busy, 1'b1);
    repeat (hold_hi) tick();
    pkt_data_next = 1'b0;
    repeat (busy_lo) tick();
    pkt_data_next = 1'b1;
    tick();
  endtask

  task automatic timeout_pkt(input bit clr_held);
    int w;
    present(4'hF, 4'hF, w);
    err_clr = clr_held;
    for (int k = 1; k <= int'(TMO); k++) begin
      tick();
      if (k == int'(TMO) - 1) chk("tmo_not_yet", timeout_err, 1'b0);
      if (k == int'(TMO)) begin
        chk("tmo_err_set", timeout_err, 1'b1);
        chk("tmo_valid_drop", pkt_data_valid, 1'b0);
        chk("tmo_idle", busy, 1'b0);
      end
    end
    tick();
    chk("tmo_after", timeout_err, clr_held ? 1'b0 : 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_cleared", timeout_err, 1'b0);
  endtask

  task automatic reset_mid(input bit in_busy);
    int w;
    present(4'hF, 4'hF, w);
    tick();
    if (in_busy) begin
      pkt_data_next = 1'b0;
      tick();
      chk("pre_rst_busy", busy, 1'b1);
    end else begin
      chk("pre_rst_valid", pkt_data_valid, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", pkt_data_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    m_ptr = 0;
    pkt_data_next = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  initial begin : monitor
    logic          prev_v;
    logic [DW-1:0] prev_d;
    prev_v = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      if (src_ready != '0) begin
        if (ready_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_src_ready got=%b exp=0000", src_ready);
        end else chk("src_ready", src_ready, ready_q.pop_front());
      end
      if (pkt_data_valid && !prev_v) begin
        if (offer_id_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_offer got=1 exp=0");
        end else begin
          chk("grant_id", grant_id, offer_id_q.pop_front());
          chk("pkt_data", pkt_data, offer_data_q.pop_front());
        end
      end
      if (pkt_data_valid && prev_v) chk("pkt_data_stable", pkt_data, prev_d);
      if (pkt_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt_done got=1 exp=0");
        end else chk("done_id", grant_id, done_q.pop_front());
      end
      prev_v = pkt_data_valid;
      prev_d = pkt_data;
    end
  end

  initial begin
    rst = 1'b1;
    src_en = 4'hF;
    src_valid = 4'hF;
    src_data = '0;
    pkt_data_next = 1'b1;
    err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_src_ready", src_ready, 4'h0);
    chk("rst_valid", pkt_data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", pkt_done, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    src_valid = '0;
    rst = 1'b0;
    tick();

    // Round-robin with every source requesting
    for (int i = 0; i < 5; i++) run_pkt(4'hF, 4'hF, 1, 9);
    // Masked sources
    for (int i = 0; i < 4; i++) run_pkt(4'b1010, 4'hF, 1, 5);
    // Single requester granted back-to-back
    for (int i = 0; i < 3; i++) run_pkt(4'hF, 4'b0100, 0, 2);
    // Back-pressure while offering
    run_pkt(4'hF, 4'hF, 20, 3);
    // Timeout, then set-wins-over-clear
    timeout_pkt(1'b0);
    timeout_pkt(1'b1);
    run_pkt(4'hF, 4'hF, 2, 4);
    // Reset mid-packet
    reset_mid(1'b1);
    run_pkt(4'hF, 4'hF, 1, 3);
    reset_mid(1'b0);
    run_pkt(4'hF, 4'hF, 1, 3);
    // Random traffic
    for (int i = 0; i < 60; i++)
      run_pkt(NS'($urandom), NS'($urandom), $urandom_range(0, 3), $urandom_range(1, 9));

    wait_idle();
    repeat (3) tick();
    chk("ready_q_left", 64'(ready_q.size()), 64'd0);
    chk("offer_q_left", 64'(offer_id_q.size()), 64'd0);
    chk("done_q_left", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
